// File: rtl/vm_pkg.sv
// Shared definitions for the ticket vending machine payout path:
// coin codes, coin values, ticket limit and dispenser state encoding.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;
  localparam logic [1:0] COIN_10   = 2'd2;
  localparam logic [1:0] COIN_50   = 2'd3;

  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;
  localparam int VAL_50 = 50;

  localparam int MAX_TKT = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TICKET,
    S_COIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin choice for an amount: 50, else 10, else 5, else none.
// Ports: amount in; coin_type (code) and coin_value (units) out.
module coin_selector
  import vm_pkg::*;
#(
  parameter int AMT_W = 7
) (
  input  logic [AMT_W-1:0] amount,
  output logic [1:0]       coin_type,
  output logic [AMT_W-1:0] coin_value
);

  always_comb begin
    coin_type  = COIN_NONE;
    coin_value = '0;
    priority case (1'b1)
      (amount >= AMT_W'(VAL_50)): begin
        coin_type  = COIN_50;
        coin_value = AMT_W'(VAL_50);
      end
      (amount >= AMT_W'(VAL_10)): begin
        coin_type  = COIN_10;
        coin_value = AMT_W'(VAL_10);
      end
      (amount >= AMT_W'(VAL_5)): begin
        coin_type  = COIN_5;
        coin_value = AMT_W'(VAL_5);
      end
      default: begin
        coin_type  = COIN_NONE;
        coin_value = '0;
      end
    endcase
  end

endmodule

// File: rtl/change_dispenser.sv
// Payout FSM: issues tickets as pulses, then change as 50/10/5 coins
// over a valid/ack handshake. Ports: req_* in, ticket/coin/done/err out.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W   = 7,
  parameter int TKT_W   = 3,
  parameter int MAX_TKT = vm_pkg::MAX_TKT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] change_in,
  input  logic [TKT_W-1:0] tickets_in,
  output logic             ticket_pulse,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic [AMT_W-1:0] remaining,
  output logic             done,
  output logic             err_odd
);

  state_e           state_q, state_d;
  logic [TKT_W-1:0] tkt_cnt_q, tkt_cnt_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] coin_val_q, coin_val_d;
  logic [1:0]       coin_type_q, coin_type_d;
  logic             coin_valid_q, coin_valid_d;
  logic             ticket_pulse_q, ticket_pulse_d;
  logic             done_q, done_d;
  logic             err_odd_q, err_odd_d;
  logic             req_ready_q, req_ready_d;

  logic [TKT_W-1:0] tkt_sat;
  logic [AMT_W-1:0] rem_new;
  logic [AMT_W-1:0] sel_in;
  logic [1:0]       sel_type;
  logic [AMT_W-1:0] sel_val;
  logic             go_coin;

  assign tkt_sat = (tickets_in > TKT_W'(MAX_TKT)) ?
                   TKT_W'(MAX_TKT) : tickets_in;

  // Selector never picks a coin larger than remaining, so no underflow.
  assign rem_new = remaining_q - coin_val_q;

  // One selector serves every entry into a coin: the fresh request,
  // the leftover after tickets, or the leftover after an acked coin.
  always_comb begin
    sel_in = remaining_q;
    unique case (state_q)
      S_IDLE:  sel_in = change_in;
      S_COIN:  sel_in = rem_new;
      default: sel_in = remaining_q;
    endcase
  end

  coin_selector #(.AMT_W(AMT_W)) u_sel (
    .amount     (sel_in),
    .coin_type  (sel_type),
    .coin_value (sel_val)
  );

  assign go_coin = (sel_type != COIN_NONE);

  always_comb begin
    state_d        = state_q;
    tkt_cnt_d      = tkt_cnt_q;
    remaining_d    = remaining_q;
    err_odd_d      = err_odd_q;
    ticket_pulse_d = 1'b0;
    coin_valid_d   = 1'b0;
    coin_type_d    = COIN_NONE;
    coin_val_d     = '0;
    done_d         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          remaining_d = change_in;
          err_odd_d   = 1'b0;
          tkt_cnt_d   = tkt_sat;
          if (tkt_sat != '0) begin
            state_d        = S_TICKET;
            ticket_pulse_d = 1'b1;
          end else if (go_coin) begin
            state_d      = S_COIN;
            coin_valid_d = 1'b1;
            coin_type_d  = sel_type;
            coin_val_d   = sel_val;
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            err_odd_d = (change_in != '0);
          end
        end
      end
      S_TICKET: begin
        tkt_cnt_d = tkt_cnt_q - TKT_W'(1);
        if (tkt_cnt_q > TKT_W'(1)) begin
          ticket_pulse_d = 1'b1;
        end else if (go_coin) begin
          state_d      = S_COIN;
          coin_valid_d = 1'b1;
          coin_type_d  = sel_type;
          coin_val_d   = sel_val;
        end else begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          err_odd_d = (remaining_q != '0);
        end
      end
      S_COIN: begin
        if (coin_ack) begin
          remaining_d = rem_new;
          if (go_coin) begin
            coin_valid_d = 1'b1;
            coin_type_d  = sel_type;
            coin_val_d   = sel_val;
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            err_odd_d = (rem_new != '0);
          end
        end else begin
          coin_valid_d = 1'b1;
          coin_type_d  = coin_type_q;
          coin_val_d   = coin_val_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tkt_cnt_q      <= '0;
      remaining_q    <= '0;
      coin_val_q     <= '0;
      coin_type_q    <= COIN_NONE;
      coin_valid_q   <= 1'b0;
      ticket_pulse_q <= 1'b0;
      done_q         <= 1'b0;
      err_odd_q      <= 1'b0;
      req_ready_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      tkt_cnt_q      <= tkt_cnt_d;
      remaining_q    <= remaining_d;
      coin_val_q     <= coin_val_d;
      coin_type_q    <= coin_type_d;
      coin_valid_q   <= coin_valid_d;
      ticket_pulse_q <= ticket_pulse_d;
      done_q         <= done_d;
      err_odd_q      <= err_odd_d;
      req_ready_q    <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign ticket_pulse = ticket_pulse_q;
  assign coin_valid   = coin_valid_q;
  assign coin_type    = coin_type_q;
  assign remaining    = remaining_q;
  assign done         = done_q;
  assign err_odd      = err_odd_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
// Drives inputs 1ns after the rising edge and samples there too.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] change_in;
  logic [2:0] tickets_in;
  logic       ticket_pulse;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ack;
  logic [6:0] remaining;
  logic       done;
  logic       err_odd;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .change_in    (change_in),
    .tickets_in   (tickets_in),
    .ticket_pulse (ticket_pulse),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .coin_ack     (coin_ack),
    .remaining    (remaining),
    .done         (done),
    .err_odd      (err_odd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; change_in = '0;
    tickets_in = '0; coin_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || ticket_pulse !== 1'b0 ||
        coin_valid !== 1'b0 || coin_type !== 2'd0 ||
        remaining !== 7'd0 || done !== 1'b0 || err_odd !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got rdy=%0b tp=%0b cv=%0b ct=%0d rem=%0d dn=%0b eo=%0b exp 1 0 0 0 0 0 0",
               req_ready, ticket_pulse, coin_valid, coin_type,
               remaining, done, err_odd);
    end
  endtask

  task automatic test_tickets_and_coins();
    // cycles T1..T7 after accept of change=65, tickets=2, ack tied high
    logic       e_tp [7] = '{1, 1, 0, 0, 0, 0, 0};
    logic       e_cv [7] = '{0, 0, 1, 1, 1, 0, 0};
    logic [1:0] e_ct [7] = '{0, 0, 3, 2, 1, 0, 0};
    logic [6:0] e_rm [7] = '{65, 65, 65, 15, 5, 0, 0};
    logic       e_dn [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic       e_rd [7] = '{0, 0, 0, 0, 0, 0, 1};
    coin_ack = 1'b1;
    change_in = 7'd65; tickets_in = 3'd2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ticket_pulse !== e_tp[i] || coin_valid !== e_cv[i] ||
          coin_type !== e_ct[i] || remaining !== e_rm[i] ||
          done !== e_dn[i] || req_ready !== e_rd[i] ||
          err_odd !== 1'b0) begin
        fails++;
        $display("FAIL t65_cycle%0d got tp=%0b cv=%0b ct=%0d rem=%0d dn=%0b rdy=%0b eo=%0b exp tp=%0b cv=%0b ct=%0d rem=%0d dn=%0b rdy=%0b eo=0",
                 i + 1, ticket_pulse, coin_valid, coin_type, remaining,
                 done, req_ready, err_odd, e_tp[i], e_cv[i], e_ct[i],
                 e_rm[i], e_dn[i], e_rd[i]);
      end
      step();
    end
  endtask

  task automatic test_delayed_ack();
    logic [6:0] e_rm [2] = '{20, 10};
    coin_ack = 1'b0;
    change_in = 7'd20; tickets_in = 3'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (coin_valid !== 1'b1 || coin_type !== 2'd2 ||
            remaining !== e_rm[c] || ticket_pulse !== 1'b0 ||
            done !== 1'b0) begin
          fails++;
          $display("FAIL hold_coin%0d_cyc%0d got cv=%0b ct=%0d rem=%0d tp=%0b dn=%0b exp cv=1 ct=2 rem=%0d tp=0 dn=0",
                   c, k, coin_valid, coin_type, remaining,
                   ticket_pulse, done, e_rm[c]);
        end
        coin_ack = (k == 2);
        step();
      end
      coin_ack = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || coin_valid !== 1'b0 || coin_type !== 2'd0 ||
        remaining !== 7'd0 || err_odd !== 1'b0) begin
      fails++;
      $display("FAIL hold_done got dn=%0b cv=%0b ct=%0d rem=%0d eo=%0b exp 1 0 0 0 0",
               done, coin_valid, coin_type, remaining, err_odd);
    end
    step();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_idle got dn=%0b rdy=%0b exp dn=0 rdy=1",
               done, req_ready);
    end
  endtask

  task automatic test_zero();
    // stray ack with no coin pending must be ignored
    coin_ack = 1'b1;
    change_in = 7'd0; tickets_in = 3'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || coin_valid !== 1'b0 || ticket_pulse !== 1'b0 ||
        req_ready !== 1'b0 || err_odd !== 1'b0) begin
      fails++;
      $display("FAIL zero_done got dn=%0b cv=%0b tp=%0b rdy=%0b eo=%0b exp 1 0 0 0 0",
               done, coin_valid, ticket_pulse, req_ready, err_odd);
    end
    step();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || coin_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_idle got dn=%0b rdy=%0b cv=%0b exp 0 1 0",
               done, req_ready, coin_valid);
    end
    coin_ack = 1'b0;
  endtask

  task automatic test_saturate_odd();
    int pulses = 0;
    coin_ack = 1'b1;
    change_in = 7'd13; tickets_in = 3'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(ticket_pulse);
      step();
    end
    checks++;
    if (pulses != 5) begin
      fails++;
      $display("FAIL sat_pulses got %0d exp 5", pulses);
    end
    checks++;
    if (ticket_pulse !== 1'b0 || coin_valid !== 1'b1 ||
        coin_type !== 2'd2 || remaining !== 7'd13) begin
      fails++;
      $display("FAIL sat_coin got tp=%0b cv=%0b ct=%0d rem=%0d exp 0 1 2 13",
               ticket_pulse, coin_valid, coin_type, remaining);
    end
    step();
    checks++;
    if (done !== 1'b1 || err_odd !== 1'b1 || remaining !== 7'd3 ||
        coin_valid !== 1'b0) begin
      fails++;
      $display("FAIL sat_done got dn=%0b eo=%0b rem=%0d cv=%0b exp 1 1 3 0",
               done, err_odd, remaining, coin_valid);
    end
    step();
    checks++;
    if (req_ready !== 1'b1 || err_odd !== 1'b1 || remaining !== 7'd3 ||
        done !== 1'b0) begin
      fails++;
      $display("FAIL sat_hold got rdy=%0b eo=%0b rem=%0d dn=%0b exp 1 1 3 0",
               req_ready, err_odd, remaining, done);
    end
    change_in = 7'd0; tickets_in = 3'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (err_odd !== 1'b0 || done !== 1'b1 || remaining !== 7'd0) begin
      fails++;
      $display("FAIL sat_clear got eo=%0b dn=%0b rem=%0d exp 0 1 0",
               err_odd, done, remaining);
    end
    step();
    coin_ack = 1'b0;
  endtask

  task automatic test_reset_mid_coin();
    int dones = 0;
    coin_ack = 1'b1;
    change_in = 7'd100; tickets_in = 3'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (coin_valid !== 1'b1 || coin_type !== 2'd3 ||
        remaining !== 7'd100) begin
      fails++;
      $display("FAIL rst_first got cv=%0b ct=%0d rem=%0d exp 1 3 100",
               coin_valid, coin_type, remaining);
    end
    step();
    checks++;
    if (coin_valid !== 1'b1 || coin_type !== 2'd3 ||
        remaining !== 7'd50) begin
      fails++;
      $display("FAIL rst_second got cv=%0b ct=%0d rem=%0d exp 1 3 50",
               coin_valid, coin_type, remaining);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || coin_valid !== 1'b0 || coin_type !== 2'd0 ||
        remaining !== 7'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got rdy=%0b cv=%0b ct=%0d rem=%0d dn=%0b exp 1 0 0 0 0",
               req_ready, coin_valid, coin_type, remaining, done);
    end
    for (int i = 0; i < 4; i++) begin
      dones += int'(done) + int'(coin_valid);
      step();
    end
    checks++;
    if (dones != 0) begin
      fails++;
      $display("FAIL rst_quiet got activity=%0d exp 0", dones);
    end
    coin_ack = 1'b0;
  endtask

  task automatic test_busy_ignore();
    logic       e_tp [5] = '{1, 0, 0, 0, 0};
    logic       e_cv [5] = '{0, 1, 1, 1, 0};
    logic [1:0] e_ct [5] = '{0, 2, 2, 1, 0};
    logic [6:0] e_rm [5] = '{25, 25, 15, 5, 0};
    logic       e_dn [5] = '{0, 0, 0, 0, 1};
    coin_ack = 1'b1;
    change_in = 7'd25; tickets_in = 3'd1; req_valid = 1'b1;
    step();
    change_in = 7'd90; tickets_in = 3'd3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ticket_pulse !== e_tp[i] || coin_valid !== e_cv[i] ||
          coin_type !== e_ct[i] || remaining !== e_rm[i] ||
          done !== e_dn[i] || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL busy_cycle%0d got tp=%0b cv=%0b ct=%0d rem=%0d dn=%0b rdy=%0b exp tp=%0b cv=%0b ct=%0d rem=%0d dn=%0b rdy=0",
                 i + 1, ticket_pulse, coin_valid, coin_type, remaining,
                 done, req_ready, e_tp[i], e_cv[i], e_ct[i], e_rm[i],
                 e_dn[i]);
      end
      if (i == 4) req_valid = 1'b0;
      step();
    end
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || remaining !== 7'd0) begin
      fails++;
      $display("FAIL busy_idle got rdy=%0b dn=%0b rem=%0d exp 1 0 0",
               req_ready, done, remaining);
    end
    coin_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tickets_and_coins();
    test_delayed_ack();
    test_zero();
    test_saturate_odd();
    test_reset_mid_coin();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
